exe_stage_md: RTL and testbench
===============================

# exe_stage_md

Parametrised execute stage for the in-order LoongArch-style pipeline, sitting between ID and MEM. It owns its ID→EXE pipeline register and the single-cycle ALU path. It adds three things over the previous execute stage: an iterative multi-cycle divider that stalls the stage, sub-word store lane and data generation with alignment checking, and a forwarding port plus flush.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DIV_EN, 1, when 0 the divider is not built, `div_en` is ignored and the stage never stalls.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `ID_signal_valid`  in  1  ID holds a valid instruction
- `ID_signal`  in  4·XLEN+25  {pc, rf_we, rf_waddr[4:0], rkd_value, res_from_mem, mem_size[1:0], mem_store, div_en, div_op[1:0], alu_op[11:0], alu_src1, alu_src2}
- `flush`  in  1  kill the instruction held in EXE and any ID capture this cycle
- `MEM_allowin`  in  1  MEM can accept
- `EXE_allowin`  out  1  EXE can capture from ID
- `data_sram_en`  out  1  SRAM request
- `data_sram_we`  out  XLEN/8  byte write enables
- `data_sram_addr`  out  XLEN  address (ALU result)
- `data_sram_wdata`  out  XLEN  lane-replicated store data
- `MEM_signal_valid`  out  1  MEM_signal is valid this cycle
- `MEM_signal`  out  2·XLEN+10  {pc, ale, res_from_mem, mem_size, rf_we, rf_waddr, result}
- `ld_EXE`  out  1  valid load in EXE, used for ID load-use stall
- `fwd_valid`, `fwd_waddr[4:0]`, `fwd_wdata[XLEN]`  out  bypass to ID

## Operation
- Capture: on `EXE_allowin && ID_signal_valid && !flush`, set `es_valid` and latch `ID_signal`.
- `EXE_allowin = !es_valid || (EXE_readygo && MEM_allowin)`.
- `EXE_readygo = !(div_en && DIV_EN) || div_done`.
- Result select: the divider result when `div_en`, otherwise the ALU result.
- `div_op[0]` selects signed; `div_op[1]` selects remainder.
- Divide by zero: quotient is all-ones, remainder is the dividend.
- Signed MIN/−1: quotient is MIN, remainder is 0.
- Store lanes: `data_sram_we` = ((1<<(1<<mem_size))−1) << addr[low lane bits], gated by `mem_store`. Data is replicated per size: byte ×XLEN/8, half ×XLEN/16, word ×XLEN/32.
- mem_size 3 is legal only when XLEN=64.
- Alignment: `ale = (res_from_mem||mem_store) && (addr & ((1<<mem_size)−1)) != 0`. When `ale` is set, no SRAM request is made and `ale` is passed down to MEM.
- Single request: `data_sram_en = es_valid && (res_from_mem||mem_store) && !ale && EXE_readygo && MEM_allowin && !flush`. This asserts only on the handoff cycle, so a stalled EXE never issues twice.
- `MEM_signal_valid = es_valid && EXE_readygo && !flush`.
- `ld_EXE = es_valid && res_from_mem`.
- `fwd_valid = es_valid && rf_we && !res_from_mem && EXE_readygo`.
- Divider FSM (in sub-module):
  - IDLE → BUSY when `es_valid && div_en && !flush`; operands are loaded and the counter is set to XLEN.
  - BUSY: one restoring-division step per cycle; → DONE when the counter reaches 0.
  - DONE → IDLE on handoff (`MEM_allowin`).
  - Any state → IDLE on `flush`.

## Timing
- Instruction in EXE in cycle 0.
- Non-divide instructions: ready in cycle 0; handoff on the first cycle with `MEM_allowin`=1.
- Divide: `div_done` (and readygo) rises in cycle XLEN+1, i.e. 33 cycles for XLEN=32. The result is held stable while `MEM_allowin`=0.
- `flush`: the `es_valid` clear, divider abort and ID-capture drop all take effect at the next edge. Outputs are suppressed in the flush cycle itself.
- `reset`: `es_valid`=0, FSM=IDLE, counter=0, `EXE_allowin`=1. All request, valid and forward outputs are 0, including during and immediately after an asynchronous assertion mid-divide.

## Structure
- Package `exe_pkg`:
  - mem_size encodings SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3
  - div_op bit indices
  - `ID_signal` and `MEM_signal` field offsets/width functions of XLEN
  - divider state enum
- Sub-module `iter_div`:
  - parameter XLEN
  - ports `clk`, `reset`, `start`, `abort`, `is_signed`, `dividend`, `divisor`, `ack`, `busy`, `done`, `quotient`, `remainder`
- The existing `alu` is instantiated unchanged.

## Test plan
- ADD 3+4, `MEM_allowin`=1: `MEM_signal_valid` in cycle 0, result 7, `fwd_valid`=1, `data_sram_en`=0.
- Signed DIV −7/2 then MOD: quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. `EXE_allowin`=0 for cycles 0–32; result and readygo appear in cycle 33.
- DIVU 5/0: quotient 0xFFFFFFFF, remainder 5. DIV 0x80000000/−1: quotient 0x80000000, remainder 0.
- ST.B to 0x1003 with rkd=0x12345678: `data_sram_we`=4'b1000, wdata 0x78787878. ST.H to 0x1001: `ale`=1 and `data_sram_en`=0.
- Load with `MEM_allowin` held 0 for 3 cycles: `ld_EXE`=1 throughout; `data_sram_en` pulses exactly once, on the release cycle.
- Flush in cycle 10 of a DIV, and reset mid-divide: FSM returns to IDLE, `MEM_signal_valid` is never raised, and `EXE_allowin`=1 the next cycle.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings, bundle layouts and divider state type for the execute stage.
package exe_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int DIV_OP_SIGNED = 0;
    localparam int DIV_OP_REM    = 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    function automatic int id_sig_w(input int xlen);
        return 4 * xlen + 25;
    endfunction

    function automatic int mem_sig_w(input int xlen);
        return 2 * xlen + 10;
    endfunction

    // LSB positions of the wide fields inside the ID and MEM bundles
    function automatic int id_pc_lsb(input int xlen);
        return 3 * xlen + 25;
    endfunction

    function automatic int id_rkd_lsb(input int xlen);
        return 2 * xlen + 19;
    endfunction

    function automatic int mem_pc_lsb(input int xlen);
        return xlen + 10;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU with one-hot operation select.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [11:0]     alu_op,
    input  logic [XLEN-1:0] alu_src1,
    input  logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] alu_result
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] add_res, sub_res, slt_res, sltu_res;
    logic [XLEN-1:0] sll_res, srl_res, sra_res;

    assign shamt    = alu_src2[SHW-1:0];
    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
    assign sltu_res = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
    assign sll_res  = alu_src1 << shamt;
    assign srl_res  = alu_src1 >> shamt;
    assign sra_res  = $signed(alu_src1) >>> shamt;

    assign alu_result = ({XLEN{alu_op[0]}}  & add_res)
                      | ({XLEN{alu_op[1]}}  & sub_res)
                      | ({XLEN{alu_op[2]}}  & slt_res)
                      | ({XLEN{alu_op[3]}}  & sltu_res)
                      | ({XLEN{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({XLEN{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({XLEN{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({XLEN{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({XLEN{alu_op[8]}}  & sll_res)
                      | ({XLEN{alu_op[9]}}  & srl_res)
                      | ({XLEN{alu_op[10]}} & sra_res)
                      | ({XLEN{alu_op[11]}} & alu_src2);

endmodule

// File: rtl/iter_div.sv
// Restoring divider, one quotient bit per cycle; signs are stripped on load and
// reapplied on the outputs so the held result stays stable in DONE.
module iter_div
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dvz_q, dvz_d;
    logic [XLEN:0]   shifted, diff;
    logic            dividend_neg, divisor_neg;

    assign dividend_neg = is_signed && dividend[XLEN-1];
    assign divisor_neg  = is_signed && divisor[XLEN-1];
    assign shifted      = {rem_q, quo_q[XLEN-1]};
    assign diff         = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dvz_d     = dvz_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d   = DIV_BUSY;
                    cnt_d     = CW'(XLEN);
                    quo_d     = dividend_neg ? -dividend : dividend;
                    dvs_d     = divisor_neg ? -divisor : divisor;
                    rem_d     = '0;
                    neg_quo_d = dividend_neg ^ divisor_neg;
                    neg_rem_d = dividend_neg;
                    dvz_d     = (divisor == '0);
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (diff[XLEN]) begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ack) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (abort) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dvz_q     <= dvz_d;
        end
    end

    // Divide by zero keeps the all-ones quotient regardless of dividend sign
    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = dvz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: ID->EXE register, ALU/divider result select, store lane and
// data generation with alignment check, single SRAM request and ID bypass.
module exe_stage_md
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DIV_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ID_signal_valid,
    input  logic [id_sig_w(XLEN)-1:0]  ID_signal,
    input  logic                       flush,
    input  logic                       MEM_allowin,
    output logic                       EXE_allowin,
    output logic                       data_sram_en,
    output logic [XLEN/8-1:0]          data_sram_we,
    output logic [XLEN-1:0]            data_sram_addr,
    output logic [XLEN-1:0]            data_sram_wdata,
    output logic                       MEM_signal_valid,
    output logic [mem_sig_w(XLEN)-1:0] MEM_signal,
    output logic                       ld_EXE,
    output logic                       fwd_valid,
    output logic [4:0]                 fwd_waddr,
    output logic [XLEN-1:0]            fwd_wdata
);
    localparam int LANE_BITS = $clog2(XLEN / 8);

    logic                      es_valid_q, es_valid_d;
    logic [id_sig_w(XLEN)-1:0] id_q, id_d;

    logic [XLEN-1:0]   pc, rkd_value, alu_src1, alu_src2, alu_result;
    logic [XLEN-1:0]   div_quo, div_rem, result;
    logic              rf_we, res_from_mem, mem_store, div_en;
    logic [4:0]        rf_waddr;
    logic [1:0]        mem_size, div_op;
    logic [11:0]       alu_op;
    logic              div_active, div_done, exe_readygo, mem_access, ale;
    logic [2:0]        size_mask;
    logic [XLEN/8-1:0] lane_mask;

    assign {pc, rf_we, rf_waddr, rkd_value, res_from_mem, mem_size, mem_store,
            div_en, div_op, alu_op, alu_src1, alu_src2} = id_q;

    alu #(.XLEN(XLEN)) u_alu (
        .alu_op     (alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result)
    );

    generate
        if (DIV_EN != 0) begin : g_div
            logic div_start, div_busy;
            assign div_start  = es_valid_q && div_en && !div_busy && !div_done && !flush;
            assign div_active = div_en;
            iter_div #(.XLEN(XLEN)) u_div (
                .clk       (clk),
                .reset     (reset),
                .start     (div_start),
                .abort     (flush),
                .is_signed (div_op[DIV_OP_SIGNED]),
                .dividend  (alu_src1),
                .divisor   (alu_src2),
                .ack       (MEM_allowin),
                .busy      (div_busy),
                .done      (div_done),
                .quotient  (div_quo),
                .remainder (div_rem)
            );
        end else begin : g_nodiv
            assign div_active = 1'b0;
            assign div_done   = 1'b0;
            assign div_quo    = '0;
            assign div_rem    = '0;
        end
    endgenerate

    assign exe_readygo = !div_active || div_done;
    assign result      = div_active ? (div_op[DIV_OP_REM] ? div_rem : div_quo) : alu_result;
    assign mem_access  = res_from_mem || mem_store;
    assign size_mask   = 3'((4'd1 << mem_size) - 4'd1);
    assign ale         = mem_access && ((alu_result[2:0] & size_mask) != 3'd0);

    always_comb begin
        lane_mask       = '1;
        data_sram_wdata = rkd_value;
        case (mem_size)
            SZ_B: begin
                lane_mask       = (XLEN/8)'(1);
                data_sram_wdata = {(XLEN/8){rkd_value[7:0]}};
            end
            SZ_H: begin
                lane_mask       = (XLEN/8)'(3);
                data_sram_wdata = {(XLEN/16){rkd_value[15:0]}};
            end
            SZ_W: begin
                lane_mask       = (XLEN/8)'(15);
                data_sram_wdata = {(XLEN/32){rkd_value[31:0]}};
            end
            default: ;
        endcase
    end

    assign data_sram_we   = mem_store ? (lane_mask << alu_result[LANE_BITS-1:0]) : '0;
    assign data_sram_addr = alu_result;

    // The request fires only on the handoff cycle so a stalled load/store issues once
    assign data_sram_en     = es_valid_q && mem_access && !ale && exe_readygo && MEM_allowin && !flush;
    assign EXE_allowin      = !es_valid_q || (exe_readygo && MEM_allowin);
    assign MEM_signal_valid = es_valid_q && exe_readygo && !flush;
    assign MEM_signal       = {pc, ale, res_from_mem, mem_size, rf_we, rf_waddr, result};
    assign ld_EXE           = es_valid_q && res_from_mem;
    assign fwd_valid        = es_valid_q && rf_we && !res_from_mem && exe_readygo;
    assign fwd_waddr        = rf_waddr;
    assign fwd_wdata        = result;

    always_comb begin
        es_valid_d = es_valid_q;
        id_d       = id_q;
        if (flush) begin
            es_valid_d = 1'b0;
        end else if (EXE_allowin) begin
            es_valid_d = ID_signal_valid;
            if (ID_signal_valid) begin
                id_d = ID_signal;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            id_q       <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            id_q       <= id_d;
        end
    end

endmodule

// File: tb/tb_exe_stage_md.sv
// Randomized self-checking bench for exe_stage_md against an arithmetic reference model.
module tb_exe_stage_md;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rkd;
        logic        res_from_mem;
        logic [1:0]  mem_size;
        logic        mem_store;
        logic        div_en;
        logic [1:0]  div_op;
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_signal_valid;
    instr_t      ID_signal;
    logic        flush;
    logic        MEM_allowin;
    logic        EXE_allowin;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        MEM_signal_valid;
    logic [73:0] MEM_signal;
    logic        ld_EXE;
    logic        fwd_valid;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;

    int total = 0;
    int bad   = 0;

    exe_stage_md #(.XLEN(XLEN), .DIV_EN(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .ID_signal_valid  (ID_signal_valid),
        .ID_signal        (ID_signal),
        .flush            (flush),
        .MEM_allowin      (MEM_allowin),
        .EXE_allowin      (EXE_allowin),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .MEM_signal_valid (MEM_signal_valid),
        .MEM_signal       (MEM_signal),
        .ld_EXE           (ld_EXE),
        .fwd_valid        (fwd_valid),
        .fwd_waddr        (fwd_waddr),
        .fwd_wdata        (fwd_wdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] refAlu(input instr_t ins);
        logic [31:0] a, b;
        int sel;
        a   = ins.src1;
        b   = ins.src2;
        sel = -1;
        for (int i = 0; i < 12; i++) if (ins.alu_op[i]) sel = i;
        case (sel)
            0:  return a + b;
            1:  return a - b;
            2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return int'(a) >>> b[4:0];
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] refResult(input instr_t ins);
        logic [31:0] a, b;
        int sa, sb;
        if (!ins.div_en) return refAlu(ins);
        a  = ins.src1;
        b  = ins.src2;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return ins.div_op[1] ? a : 32'hFFFF_FFFF;
        if (ins.div_op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return ins.div_op[1] ? 32'd0 : 32'h8000_0000;
            return ins.div_op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return ins.div_op[1] ? a % b : a / b;
    endfunction

    function automatic instr_t mkAlu(input int op, input logic [31:0] a, input logic [31:0] b);
        instr_t ins;
        ins            = '0;
        ins.pc         = $urandom;
        ins.rf_we      = 1'b1;
        ins.rf_waddr   = 5'($urandom_range(1, 31));
        ins.rkd        = $urandom;
        ins.alu_op[op] = 1'b1;
        ins.src1       = a;
        ins.src2       = b;
        return ins;
    endfunction

    function automatic instr_t mkDiv(input logic [1:0] dop, input logic [31:0] a, input logic [31:0] b);
        instr_t ins;
        ins        = mkAlu(0, a, b);
        ins.alu_op = '0;
        ins.div_en = 1'b1;
        ins.div_op = dop;
        return ins;
    endfunction

    function automatic instr_t mkMem(input bit store, input logic [1:0] size, input logic [31:0] base,
                                     input logic [31:0] off, input logic [31:0] rkd);
        instr_t ins;
        ins              = mkAlu(0, base, off);
        ins.mem_store    = store;
        ins.res_from_mem = !store;
        ins.rf_we        = !store;
        ins.mem_size     = size;
        ins.rkd          = rkd;
        return ins;
    endfunction

    // Presents one instruction, then checks every cycle until it leaves EXE.
    task automatic applyStimulus(input instr_t ins, input int hold);
        logic [31:0] res, addr, exp_wd;
        logic [3:0]  exp_we;
        logic [73:0] exp_mem;
        logic        ale, mem;
        int          n, off, ready, handoff;
        instr_t      junk;
        res     = refResult(ins);
        addr    = refAlu(ins);
        mem     = ins.res_from_mem || ins.mem_store;
        n       = 1 << ins.mem_size;
        off     = int'(addr % 4);
        ale     = mem && (addr % n != 0);
        ready   = ins.div_en ? XLEN + 1 : 0;
        handoff = (hold > ready) ? hold : ready;
        exp_we  = '0;
        exp_wd  = '0;
        for (int i = 0; i < 4; i++) begin
            if (ins.mem_store && i >= off && i < off + n) exp_we[i] = 1'b1;
            exp_wd[8*i +: 8] = ins.rkd[8*(i % n) +: 8];
        end
        exp_mem = {ins.pc, ale, ins.res_from_mem, ins.mem_size, ins.rf_we, ins.rf_waddr, res};

        ID_signal       = ins;
        ID_signal_valid = 1'b1;
        MEM_allowin     = (hold == 0);
        #1;
        checkOutput("allowin_before", EXE_allowin, 1'b1);
        @(posedge clk);
        #1;
        ID_signal_valid = 1'b0;
        junk            = ins;
        junk.src1       = ~ins.src1;
        junk.pc         = ~ins.pc;
        ID_signal       = junk;
        for (int c = 0; c <= handoff; c++) begin
            MEM_allowin = (c >= hold);
            #1;
            checkOutput("mem_valid", MEM_signal_valid, c >= ready);
            checkOutput("exe_allowin", EXE_allowin, c == handoff);
            checkOutput("sram_en", data_sram_en, (c == handoff) && mem && !ale);
            checkOutput("ld_exe", ld_EXE, ins.res_from_mem);
            checkOutput("fwd_valid", fwd_valid, ins.rf_we && !ins.res_from_mem && (c >= ready));
            if (c >= ready) begin
                checkOutput("mem_signal", MEM_signal, exp_mem);
                checkOutput("fwd_wdata", fwd_wdata, res);
            end
            if (c == handoff) begin
                checkOutput("sram_we", data_sram_we, exp_we);
                if (mem) checkOutput("sram_addr", data_sram_addr, addr);
                if (ins.mem_store) checkOutput("sram_wdata", data_sram_wdata, exp_wd);
            end
            @(posedge clk);
            #1;
        end
        #1;
        checkOutput("drain_valid", MEM_signal_valid, 1'b0);
        checkOutput("drain_allowin", EXE_allowin, 1'b1);
    endtask

    task automatic startDiv(input int cycles);
        ID_signal       = mkDiv(2'b01, $urandom, 32'd3);
        ID_signal_valid = 1'b1;
        MEM_allowin     = 1'b1;
        @(posedge clk);
        #1;
        ID_signal_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            #1;
            checkOutput("div_early_valid", MEM_signal_valid, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        instr_t r;
        int     kind;
        logic [31:0] a, b;
        reset           = 1'b1;
        flush           = 1'b0;
        MEM_allowin     = 1'b1;
        ID_signal_valid = 1'b0;
        ID_signal       = '0;
        #1;
        checkOutput("rst_allowin", EXE_allowin, 1'b1);
        checkOutput("rst_valid", MEM_signal_valid, 1'b0);
        checkOutput("rst_sram_en", data_sram_en, 1'b0);
        checkOutput("rst_fwd", fwd_valid, 1'b0);
        checkOutput("rst_ld", ld_EXE, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(mkAlu(0, 32'd3, 32'd4), 0);
        applyStimulus(mkDiv(2'b01, 32'hFFFF_FFF9, 32'd2), 0);
        applyStimulus(mkDiv(2'b11, 32'hFFFF_FFF9, 32'd2), 0);
        applyStimulus(mkDiv(2'b00, 32'd5, 32'd0), 0);
        applyStimulus(mkDiv(2'b10, 32'd5, 32'd0), 1);
        applyStimulus(mkDiv(2'b01, 32'h8000_0000, 32'hFFFF_FFFF), 0);
        applyStimulus(mkDiv(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 0);
        applyStimulus(mkDiv(2'b01, 32'hFFFF_FFF9, 32'd0), 0);
        applyStimulus(mkMem(1'b1, 2'd0, 32'h1000, 32'd3, 32'h1234_5678), 0);
        applyStimulus(mkMem(1'b1, 2'd1, 32'h1000, 32'd1, 32'h1234_5678), 0);
        applyStimulus(mkMem(1'b0, 2'd2, 32'h2000, 32'd4, 32'd0), 3);
        applyStimulus(mkAlu(10, 32'h8000_0010, 32'd4), 2);

        // Flush in cycle 10 of a divide
        startDiv(10);
        flush = 1'b1;
        #1;
        checkOutput("flush_valid", MEM_signal_valid, 1'b0);
        checkOutput("flush_sram_en", data_sram_en, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        checkOutput("flush_allowin", EXE_allowin, 1'b1);
        checkOutput("flush_after_valid", MEM_signal_valid, 1'b0);

        // A capture offered during flush is dropped
        ID_signal       = mkAlu(0, 32'd1, 32'd2);
        ID_signal_valid = 1'b1;
        flush           = 1'b1;
        @(posedge clk);
        #1;
        ID_signal_valid = 1'b0;
        flush           = 1'b0;
        #1;
        checkOutput("flush_drop_valid", MEM_signal_valid, 1'b0);
        checkOutput("flush_drop_allowin", EXE_allowin, 1'b1);
        applyStimulus(mkDiv(2'b00, 32'd100, 32'd7), 0);

        // Asynchronous reset in the middle of a divide
        startDiv(10);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("amid_valid", MEM_signal_valid, 1'b0);
        checkOutput("amid_allowin", EXE_allowin, 1'b1);
        checkOutput("amid_fwd", fwd_valid, 1'b0);
        checkOutput("amid_sram_en", data_sram_en, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("areset_after_valid", MEM_signal_valid, 1'b0);
        checkOutput("areset_after_allowin", EXE_allowin, 1'b1);
        applyStimulus(mkDiv(2'b01, 32'hFFFF_FF00, 32'd9), 0);

        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: r = mkAlu($urandom_range(0, 11), $urandom, $urandom);
                1: begin
                    a = $urandom;
                    case ($urandom_range(0, 4))
                        0: b = 32'd0;
                        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                        2: b = $urandom_range(1, 20);
                        3: b = -32'($urandom_range(1, 20));
                        default: b = $urandom;
                    endcase
                    r = mkDiv(2'($urandom_range(0, 3)), a, b);
                end
                2: r = mkMem(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 15), $urandom);
                default: r = mkMem(1'b0, 2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 15), $urandom);
            endcase
            applyStimulus(r, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
